// File: rtl/ps2_kbd_host_tx_if.sv
// rtl/ps2_kbd_host_tx_if.sv - command handshake bundle for the PS/2 host transmitter
//
// Purpose: groups the request/response signals between a command source and
// ps2_kbd_host_tx.
// Signals:
//   tx_valid  request to send tx_data
//   tx_data   command byte, latched by the transmitter at accept
//   tx_ready  transmitter idle; accept = tx_valid & tx_ready
//   tx_done   1-cycle pulse: frame sent and device ACK seen
//   tx_err    1-cycle pulse: no ACK or timeout
//   busy      ~tx_ready
// Modports: master = command source, slave = transmitter.

interface ps2_kbd_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;
   logic       busy;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_done, tx_err, busy
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_done, tx_err, busy
   );
endinterface

// File: rtl/ps2_kbd_host_tx.sv
// rtl/ps2_kbd_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Purpose: sends one command byte per accepted request to a PS/2 keyboard
// (e.g. 0xED set-LEDs, 0xFF reset) over the open-drain clock/data pins and
// checks the device ACK. Pins are driven through "drive low" enables; the pad
// is oe ? 1'b0 : 1'bz.
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   tx                command handshake (slave modport of ps2_kbd_host_tx_if)
//   kbd_clk_in        raw KbdClk pin level (asynchronous)
//   kbd_data_in       raw KbdData pin level (asynchronous)
//   kbd_clk_drv_low   1 = pull KbdClk low, 0 = release
//   kbd_data_drv_low  1 = pull KbdData low, 0 = release
// Parameters:
//   INHIBIT_CYCLES    cycles KbdClk is held low before the start bit (>= 2)
//   TIMEOUT_CYCLES    max cycles between device clock falling edges (>= 3)
//   FILTER_LEN        consecutive equal synced samples to change filtered level

module ps2_kbd_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int FILTER_LEN     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   ps2_kbd_host_tx_if.slave   tx,
   input  logic               kbd_clk_in,
   input  logic               kbd_data_in,
   output logic               kbd_clk_drv_low,
   output logic               kbd_data_drv_low
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_ERR
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning: bit 0 = KbdClk, bit 1 = KbdData
   // ------------------------------------------------------------------
   logic [1:0]            sync1;
   logic [1:0]            sync2;
   logic [1:0]            filt;
   logic [1:0][FLT_W-1:0] fcnt;
   logic                  clk_filt_d;
   logic                  fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 2'b11;
         sync2      <= 2'b11;
         filt       <= 2'b11;
         fcnt       <= '0;
         clk_filt_d <= 1'b1;
      end else begin
         sync1      <= {kbd_data_in, kbd_clk_in};
         sync2      <= sync1;
         clk_filt_d <= filt[0];
         for (int i = 0; i < 2; i++) begin
            // The run counter tracks how long the synced level has disagreed
            // with the filtered level; any agreeing sample restarts the run.
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FLT_W'(FILTER_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign fall = clk_filt_d & ~filt[0];

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   state_t          state;
   logic [7:0]      tx_byte;
   logic            parity;
   logic [3:0]      bitcnt;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  toc;
   logic            timeout;
   logic            ready_q;
   logic            done_q;
   logic            err_q;

   // toc holds cycles since the last fall (or START entry). The trip point is
   // two short of the limit because ERR spends one cycle before pulsing, so the
   // error pulse lands exactly TIMEOUT_CYCLES after the reference point.
   assign timeout = (toc == TO_W'(TIMEOUT_CYCLES - 2)) && !fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         tx_byte          <= '0;
         parity           <= 1'b0;
         bitcnt           <= '0;
         inh_cnt          <= '0;
         toc              <= '0;
         ready_q          <= 1'b1;
         done_q           <= 1'b0;
         err_q            <= 1'b0;
         kbd_clk_drv_low  <= 1'b0;
         kbd_data_drv_low <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         if (state == S_START || state == S_SHIFT ||
             state == S_ACK   || state == S_WAIT_IDLE) begin
            toc <= fall ? '0 : toc + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (tx.tx_valid) begin
                  tx_byte          <= tx.tx_data;
                  parity           <= ~^tx.tx_data;
                  inh_cnt          <= '0;
                  toc              <= '0;
                  ready_q          <= 1'b0;
                  kbd_clk_drv_low  <= 1'b1;
                  kbd_data_drv_low <= 1'b0;
                  state            <= S_INHIBIT;
               end
            end

            S_INHIBIT: begin
               inh_cnt <= inh_cnt + 1'b1;
               // Data goes low one cycle before the clock is released so the
               // device sees a request-to-send when the inhibit ends.
               if (inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) begin
                  kbd_data_drv_low <= 1'b1;
               end
               if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                  kbd_clk_drv_low <= 1'b0;
                  bitcnt          <= '0;
                  toc             <= '0;
                  state           <= S_START;
               end
            end

            S_START: begin
               if (timeout) begin
                  kbd_data_drv_low <= 1'b0;
                  state            <= S_ERR;
               end else if (fall) begin
                  kbd_data_drv_low <= ~tx_byte[0];
                  bitcnt           <= 4'd1;
                  state            <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (timeout) begin
                  kbd_data_drv_low <= 1'b0;
                  state            <= S_ERR;
               end else if (fall) begin
                  bitcnt <= bitcnt + 4'd1;
                  if (bitcnt <= 4'd7) begin
                     kbd_data_drv_low <= ~tx_byte[bitcnt[2:0]];
                  end else if (bitcnt == 4'd8) begin
                     kbd_data_drv_low <= ~parity;
                  end else begin
                     // stop bit: release the line and let the device ACK
                     kbd_data_drv_low <= 1'b0;
                     state            <= S_ACK;
                  end
               end
            end

            S_ACK: begin
               if (timeout) begin
                  state <= S_ERR;
               end else if (fall) begin
                  state <= filt[1] ? S_ERR : S_WAIT_IDLE;
               end
            end

            S_WAIT_IDLE: begin
               if (timeout) begin
                  state <= S_ERR;
               end else if (filt == 2'b11) begin
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state   <= S_IDLE;
               end
            end

            S_ERR: begin
               err_q            <= 1'b1;
               ready_q          <= 1'b1;
               kbd_clk_drv_low  <= 1'b0;
               kbd_data_drv_low <= 1'b0;
               state            <= S_IDLE;
            end

            default: begin
               ready_q          <= 1'b1;
               kbd_clk_drv_low  <= 1'b0;
               kbd_data_drv_low <= 1'b0;
               state            <= S_IDLE;
            end
         endcase
      end
   end

   assign tx.tx_ready = ready_q;
   assign tx.busy     = ~ready_q;
   assign tx.tx_done  = done_q;
   assign tx.tx_err   = err_q;

endmodule
